// File: rtl/buffer_sender_pkg.sv
// Shared constants for buffer_sender: byte width and the 3-bit FSM state encoding.
package buffer_sender_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRead   = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StSend   = 3'd3;
  localparam logic [2:0] StGuard  = 3'd4;
  localparam logic [2:0] StWait   = 3'd5;
  localparam logic [2:0] StCsum   = 3'd6;
  localparam logic [2:0] StFinish = 3'd7;

endpackage

// File: rtl/buffer_sender_if.sv
// Control, sample-RAM read and UART TX signals of buffer_sender; master is the sender side.
interface buffer_sender_if
  import buffer_sender_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);

  logic              iStart;
  logic [ADDR_W-1:0] iBaseAddr;
  logic [ADDR_W:0]   iLength;
  logic [ADDR_W-1:0] oAddress;
  logic              oRdEn;
  logic [DATA_W-1:0] iData;
  logic [BYTE_W-1:0] oTxData;
  logic              oTxSend;
  logic              iTxBusy;
  logic              oBusy;
  logic              oDone;

  modport master (
    input  iStart, iBaseAddr, iLength, iData, iTxBusy,
    output oAddress, oRdEn, oTxData, oTxSend, oBusy, oDone
  );

  modport slave (
    output iStart, iBaseAddr, iLength, iData, iTxBusy,
    input  oAddress, oRdEn, oTxData, oTxSend, oBusy, oDone
  );

endinterface

// File: rtl/byte_unpacker.sv
// Word shift register that hands out a RAM word LSB byte first, with a last-byte flag.
module byte_unpacker
  import buffer_sender_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [BYTE_W-1:0] next_byte_o,
  output logic              last_o
);

  localparam int unsigned Bytes = DATA_W / BYTE_W;
  localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [IdxW-1:0]   rem_q, rem_d;

  always_comb begin
    word_d = word_q;
    rem_d  = rem_q;
    if (load_i) begin
      word_d = data_i;
      rem_d  = IdxW'(Bytes - 1);
    end else if (shift_i) begin
      word_d = word_q >> BYTE_W;
      rem_d  = rem_q - IdxW'(1);
    end
  end

  // Byte that will be current after this cycle, so the caller can register it as it moves on.
  assign next_byte_o = word_d[BYTE_W-1:0];
  assign last_o      = (rem_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      rem_q  <= '0;
    end else begin
      word_q <= word_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/buffer_sender.sv
// Streams a window of sample RAM out through a byte-wide UART TX.
// BUFFER_SENDER_CHECKSUM_EN appends the modulo-256 sum of the payload bytes.
module buffer_sender
  import buffer_sender_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input logic             iClock,
  input logic             iReset_n,
  buffer_sender_if.master bus
);

  localparam int unsigned LatW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] OneWord = (ADDR_W + 1)'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   left_q, left_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              rd_en_q, rd_en_d;
  logic              tx_send_q, tx_send_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef BUFFER_SENDER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  logic              upk_load, upk_shift, upk_last;
  logic [BYTE_W-1:0] upk_next;

  byte_unpacker #(
    .DATA_W (DATA_W)
  ) u_unpacker (
    .clk_i       (iClock),
    .rst_ni      (iReset_n),
    .load_i      (upk_load),
    .shift_i     (upk_shift),
    .data_i      (bus.iData),
    .next_byte_o (upk_next),
    .last_o      (upk_last)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    lat_d     = lat_q;
    upk_load  = 1'b0;
    upk_shift = 1'b0;
`ifdef BUFFER_SENDER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.iStart) begin
          addr_d = bus.iBaseAddr;
          left_d = bus.iLength;
          lat_d  = LatW'(RD_LAT - 1);
`ifdef BUFFER_SENDER_CHECKSUM_EN
          csum_d = '0;
          state_d = (bus.iLength == '0) ? StCsum : StRead;
`else
          state_d = (bus.iLength == '0) ? StFinish : StRead;
`endif
        end
      end
      StRead: begin
        if (lat_q == '0) state_d = StLoad;
        else             lat_d   = lat_q - LatW'(1);
      end
      StLoad: begin
        upk_load = 1'b1;
        state_d  = StSend;
      end
      StSend: begin
`ifdef BUFFER_SENDER_CHECKSUM_EN
        csum_d = csum_q + tx_data_q;
`endif
        state_d = StGuard;
      end
      StGuard: state_d = StWait;
      StWait: begin
        // left_q is zero only while the checksum byte is in flight.
        if (!bus.iTxBusy) begin
          if (left_q != '0 && !upk_last) begin
            upk_shift = 1'b1;
            state_d   = StSend;
          end else if (left_q > OneWord) begin
            addr_d  = addr_q + ADDR_W'(1);
            left_d  = left_q - OneWord;
            lat_d   = LatW'(RD_LAT - 1);
            state_d = StRead;
`ifdef BUFFER_SENDER_CHECKSUM_EN
          end else if (left_q == OneWord) begin
            left_d  = '0;
            state_d = StCsum;
`endif
          end else begin
            state_d = StFinish;
          end
        end
      end
`ifdef BUFFER_SENDER_CHECKSUM_EN
      StCsum: state_d = StGuard;
`endif
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the state being entered so they line up with that state.
  always_comb begin
    rd_en_d   = (state_d == StRead) && (state_q != StRead);
    tx_send_d = (state_d == StSend) || (state_d == StCsum);
    tx_data_d = tx_data_q;
    if (state_d == StSend) tx_data_d = upk_next;
`ifdef BUFFER_SENDER_CHECKSUM_EN
    if (state_d == StCsum) tx_data_d = csum_d;
`endif
    busy_d = (state_d != StIdle);
    done_d = (state_q == StFinish);
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      left_q    <= '0;
      lat_q     <= '0;
      rd_en_q   <= 1'b0;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BUFFER_SENDER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      lat_q     <= lat_d;
      rd_en_q   <= rd_en_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BUFFER_SENDER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign bus.oAddress = addr_q;
  assign bus.oRdEn    = rd_en_q;
  assign bus.oTxData  = tx_data_q;
  assign bus.oTxSend  = tx_send_q;
  assign bus.oBusy    = busy_q;
  assign bus.oDone    = done_q;

endmodule

// File: tb/tb_buffer_sender.sv
// Directed bench: byte-wide sender (A) and 32-bit / 4-bit-address / RD_LAT=2 sender (B).
module tb_buffer_sender;

`ifdef BUFFER_SENDER_CHECKSUM_EN
  localparam int Cs = 1;
`else
  localparam int Cs = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buffer_sender_if #(.ADDR_W(16), .DATA_W(8))  a_if ();
  buffer_sender_if #(.ADDR_W(4),  .DATA_W(32)) b_if ();

  buffer_sender #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1)) dut_a (
    .iClock   (clk),
    .iReset_n (rst_n),
    .bus      (a_if.master)
  );

  buffer_sender #(.ADDR_W(4), .DATA_W(32), .RD_LAT(2)) dut_b (
    .iClock   (clk),
    .iReset_n (rst_n),
    .bus      (b_if.master)
  );

  // RAM models: A has one cycle of read latency, B two.
  logic [7:0]  mem_a [0:65535];
  logic [31:0] mem_b [0:15];
  logic [7:0]  a_rd = '0;
  logic [31:0] b_rd1 = '0, b_rd2 = '0;
  always @(posedge clk) begin
    if (a_if.oRdEn) a_rd <= mem_a[a_if.oAddress];
    if (b_if.oRdEn) b_rd1 <= mem_b[b_if.oAddress];
    b_rd2 <= b_rd1;
  end
  assign a_if.iData = a_rd;
  assign b_if.iData = b_rd2;

  // UART models: busy from the cycle after a send for 10 (A) or 3 (B) cycles.
  int a_txc, b_txc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_txc <= 0;
      b_txc <= 0;
    end else begin
      if (a_if.oTxSend) a_txc <= 10; else if (a_txc > 0) a_txc <= a_txc - 1;
      if (b_if.oTxSend) b_txc <= 3;  else if (b_txc > 0) b_txc <= b_txc - 1;
    end
  end
  assign a_if.iTxBusy = (a_txc != 0);
  assign b_if.iTxBusy = (b_txc != 0);

  // Monitors; cycle numbers count from the edge that accepts iStart (cycle 0).
  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  logic [7:0]  a_bytes[$], b_bytes[$];
  logic [15:0] a_addrs[$];
  logic [3:0]  b_addrs[$];
  int a_done, b_done, a_done_at, a_first, b_first, a_sp, b_sp;

  always @(negedge clk) begin
    if (a_if.oRdEn) a_addrs.push_back(a_if.oAddress);
    if (a_if.oTxSend) begin
      if (a_first < 0) a_first = pcnt - a_sp + 1;
      a_bytes.push_back(a_if.oTxData);
    end
    if (a_if.oDone) begin
      a_done++;
      a_done_at = pcnt - a_sp + 1;
    end
    if (b_if.oRdEn) b_addrs.push_back(b_if.oAddress);
    if (b_if.oTxSend) begin
      if (b_first < 0) b_first = pcnt - b_sp + 1;
      b_bytes.push_back(b_if.oTxData);
    end
    if (b_if.oDone) b_done++;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_a(input logic [15:0] base, input logic [16:0] len);
    a_bytes.delete();
    a_addrs.delete();
    a_done = 0;
    a_first = -1;
    a_if.iBaseAddr = base;
    a_if.iLength = len;
    a_if.iStart = 1'b1;
    a_sp = pcnt + 1;
    step(1);
    a_if.iStart = 1'b0;
  endtask

  task automatic start_b(input logic [3:0] base, input logic [4:0] len);
    b_bytes.delete();
    b_addrs.delete();
    b_done = 0;
    b_first = -1;
    b_if.iBaseAddr = base;
    b_if.iLength = len;
    b_if.iStart = 1'b1;
    b_sp = pcnt + 1;
    step(1);
    b_if.iStart = 1'b0;
  endtask

  task automatic wait_a(input string tag, input int budget);
    int n = 0;
    while (a_done == 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(a_done != 0), 32'd1);
  endtask

  task automatic wait_b(input string tag, input int budget);
    int n = 0;
    while (b_done == 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(b_done != 0), 32'd1);
  endtask

  task automatic chk_a_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(a_if.oBusy), 32'd0);
    chk({tag, "_done"}, 32'(a_if.oDone), 32'd0);
    chk({tag, "_send"}, 32'(a_if.oTxSend), 32'd0);
    chk({tag, "_rden"}, 32'(a_if.oRdEn), 32'd0);
    chk({tag, "_addr"}, 32'(a_if.oAddress), 32'd0);
    chk({tag, "_txd"}, 32'(a_if.oTxData), 32'd0);
  endtask

  initial begin
    a_if.iStart = 1'b0;
    a_if.iBaseAddr = '0;
    a_if.iLength = '0;
    b_if.iStart = 1'b0;
    b_if.iBaseAddr = '0;
    b_if.iLength = '0;
    for (int i = 0; i < 65536; i++) mem_a[i] = 8'h00;
    mem_a[16'h10] = 8'h11;
    mem_a[16'h11] = 8'h22;
    mem_a[16'h12] = 8'h33;
    for (int i = 16'h20; i < 16'h28; i++) mem_a[i] = 8'hAA;
    for (int i = 0; i < 16; i++) mem_b[i] = 32'h01010101 * i;
    mem_b[5] = 32'hA1B2C3D4;

    // Reset state
    step(3);
    chk_a_idle_outputs("rst_a");
    chk("rst_b_busy", 32'(b_if.oBusy), 32'd0);
    chk("rst_b_send", 32'(b_if.oTxSend), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Three bytes from 0x10
    start_a(16'h0010, 17'd3);
    wait_a("t1_timeout", 600);
    chk("t1_nbytes", 32'(a_bytes.size()), 32'(3 + Cs));
    chk("t1_b0", 32'(a_bytes[0]), 32'h11);
    chk("t1_b1", 32'(a_bytes[1]), 32'h22);
    chk("t1_b2", 32'(a_bytes[2]), 32'h33);
`ifdef BUFFER_SENDER_CHECKSUM_EN
    chk("t1_csum", 32'(a_bytes[3]), 32'h66);
`endif
    chk("t1_first_send", 32'(a_first), 32'd3);
    chk("t1_naddr", 32'(a_addrs.size()), 32'd3);
    chk("t1_addr2", 32'(a_addrs[2]), 32'h12);
    step(20);
    chk("t1_done_once", 32'(a_done), 32'd1);
    chk("t1_idle", 32'(a_if.oBusy), 32'd0);

    // Zero-length window
    start_a(16'h0010, 17'd0);
    wait_a("len0_timeout", 200);
    step(5);
`ifdef BUFFER_SENDER_CHECKSUM_EN
    chk("len0_nbytes", 32'(a_bytes.size()), 32'd1);
    chk("len0_csum", 32'(a_bytes[0]), 32'h00);
`else
    chk("len0_nbytes", 32'(a_bytes.size()), 32'd0);
    chk("len0_done_at", 32'(a_done_at), 32'd2);
`endif
    chk("len0_done_once", 32'(a_done), 32'd1);

    // iStart while busy is ignored
    start_a(16'h0010, 17'd2);
    step(5);
    a_if.iBaseAddr = 16'h0020;
    a_if.iLength = 17'd5;
    a_if.iStart = 1'b1;
    step(1);
    a_if.iStart = 1'b0;
    wait_a("ign_timeout", 600);
    step(20);
    chk("ign_nbytes", 32'(a_bytes.size()), 32'(2 + Cs));
    chk("ign_b1", 32'(a_bytes[1]), 32'h22);
    chk("ign_naddr", 32'(a_addrs.size()), 32'd2);
    chk("ign_done_once", 32'(a_done), 32'd1);

    // Reset in the middle of a byte, then restart from a new base
    start_a(16'h0010, 17'd3);
    for (int n = 0; n < 50 && a_bytes.size() == 0; n++) step(1);
    chk("mid_sent_one", 32'(a_bytes.size()), 32'd1);
    step(3);
    rst_n = 1'b0;
    #1;
    chk_a_idle_outputs("mid_rst");
    step(2);
    rst_n = 1'b1;
    step(2);
    start_a(16'h0011, 17'd2);
    wait_a("rs_timeout", 600);
    chk("rs_nbytes", 32'(a_bytes.size()), 32'(2 + Cs));
    chk("rs_b0", 32'(a_bytes[0]), 32'h22);
    chk("rs_b1", 32'(a_bytes[1]), 32'h33);
    chk("rs_addr0", 32'(a_addrs[0]), 32'h11);

    // 32-bit word goes out LSB first
    start_b(4'h5, 5'd1);
    wait_b("w32_timeout", 300);
    chk("w32_nbytes", 32'(b_bytes.size()), 32'(4 + Cs));
    chk("w32_b0", 32'(b_bytes[0]), 32'hD4);
    chk("w32_b1", 32'(b_bytes[1]), 32'hC3);
    chk("w32_b2", 32'(b_bytes[2]), 32'hB2);
    chk("w32_b3", 32'(b_bytes[3]), 32'hA1);
`ifdef BUFFER_SENDER_CHECKSUM_EN
    chk("w32_csum", 32'(b_bytes[4]), 32'hEA);
`endif
    chk("w32_first_send", 32'(b_first), 32'd4);
    step(3);

    // Window wrapping past the top address
    start_b(4'hE, 5'd4);
    wait_b("wrap_timeout", 600);
    chk("wrap_naddr", 32'(b_addrs.size()), 32'd4);
    chk("wrap_a0", 32'(b_addrs[0]), 32'hE);
    chk("wrap_a1", 32'(b_addrs[1]), 32'hF);
    chk("wrap_a2", 32'(b_addrs[2]), 32'h0);
    chk("wrap_a3", 32'(b_addrs[3]), 32'h1);
    chk("wrap_b4", 32'(b_bytes[4]), 32'h0F);
    chk("wrap_b12", 32'(b_bytes[12]), 32'h01);
    chk("wrap_nbytes", 32'(b_bytes.size()), 32'(16 + Cs));
`ifdef BUFFER_SENDER_CHECKSUM_EN
    chk("wrap_csum", 32'(b_bytes[16]), 32'h78);
`endif
    step(3);

    // Full-memory dump includes the top address
    start_b(4'h0, 5'd16);
    wait_b("full_timeout", 3000);
    chk("full_naddr", 32'(b_addrs.size()), 32'd16);
    chk("full_last_addr", 32'(b_addrs[15]), 32'hF);
    chk("full_nbytes", 32'(b_bytes.size()), 32'(64 + Cs));
    chk("full_last_byte", 32'(b_bytes[63]), 32'h0F);
`ifdef BUFFER_SENDER_CHECKSUM_EN
    chk("full_csum", 32'(b_bytes[64]), 32'hB6);
`endif
    step(10);
    chk("full_done_once", 32'(b_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
